q15_divider: RTL and testbench
==============================

// Module: q15_divider
// PURPOSE
//   Sequential signed Q15-format divider: res = a / b, with WIDTH-bit two's-complement operands and FRAC fractional bits.
//   It is the inverse counterpart of the combinational Q15 multiplier and uses the same special encodings:
//   NaN = 0x8000_0000_0000_0000, +inf = 0x7FFF_FFFF_FFFF_FFFF, -inf = 0x8000_0000_0000_0001, zero = 0.
//   It is a radix-2 restoring divider on magnitudes, one quotient bit per cycle, with valid/ready on both sides.
//   Used by the shading/intersection datapath wherever a reciprocal or ratio is needed.
// PARAMETERS
//   WIDTH  64  operand/result width (bits)
//   FRAC   48  fractional bits; 1.0 = 1<<FRAC
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      operands a,b valid
//   in_ready   out  1      divider can accept (state IDLE)
//   a          in   WIDTH  dividend, signed Q15
//   b          in   WIDTH  divisor, signed Q15
//   out_valid  out  1      res valid; held until out_ready
//   out_ready  in   1      consumer accepts res
//   res        out  WIDTH  quotient, signed Q15 incl. special encodings
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, res=0, counter=0; any in-flight division is discarded.
//   FSM: IDLE -(in_valid, special case)-> DONE; IDLE -(in_valid, regular)-> DIV; DIV -(cnt==WIDTH+FRAC-1)-> DONE;
//        DONE -(out_ready)-> IDLE. in_ready = (state==IDLE) only; there is no accept in the same cycle as an output handshake.
//   Capture (IDLE & in_valid): latch sign = sa^sb, |a|, |b|, and special-case flags from the decoder on both operands.
//   Special cases, resolved at capture, in priority order:
//     NaN in either operand, inf/inf, or 0/0            -> NaN
//     a=inf, or b=0 with a!=0                           -> inf, sign = sa^sb (b=0: sign = sa)
//     a=0 or b=inf (other operand finite)               -> 0
//   Regular path: N = |a| << FRAC (WIDTH+FRAC bits), D = |b|.
//     Per cycle: rem = {rem,N[msb]}; if rem>=D then rem-=D, qbit=1; shift N.
//     Total WIDTH+FRAC iterations; remainder width WIDTH+1.
//   Quotient is truncated toward zero.
//     Sticky ovf is set if any quotient bit >= bit WIDTH-1 is 1, or if the final magnitude is >= 0x7FFF_FFFF_FFFF_FFFF.
//     ovf -> +inf/-inf by sign; else res = sign ? -q : q. A zero magnitude always gives res=0 (never -0).
//   Latency: regular = 1 capture + WIDTH+FRAC iterations + out_valid the next cycle (114 cycles, in_valid to out_valid).
//     Special cases: out_valid one cycle after capture.
//   out_valid/res stay stable while out_ready=0. in_valid is ignored outside IDLE.
//   |x| never overflows, because 0x8000..0 is NaN.
// STRUCTURE
//   Package q15_pkg holds:
//     Q15_WIDTH, Q15_FRAC, Q15_NAN, Q15_POS_INF, Q15_NEG_INF, Q15_ONE;
//     state enum {IDLE, DIV, DONE}.
//   Operand classification reuses the existing Q15 decoder (sign/nan/zero/inf); there are two instances.
//   Sub-module q15_div_core: unsigned iterative restoring core.
//     Ports: start, N, D -> done, q, ovf.
//     The top level owns the handshake, special cases, sign and saturation.
// TESTING
//   3.0/2.0: a=0x0003_0000_0000_0000, b=0x0002_0000_0000_0000 -> res=0x0001_8000_0000_0000, out_valid at cycle 114.
//   -1.0/3.0: a=0xFFFF_0000_0000_0000, b=0x0003_0000_0000_0000 -> res=0xFFFF_AAAA_AAAA_AAAB (truncated toward 0).
//   Specials: 1.0/0 -> 0x7FFF_FFFF_FFFF_FFFF; -1.0/0 -> 0x8000_0000_0000_0001; 0/0 -> NaN;
//     NaN/1.0 -> NaN; 1.0/+inf -> 0. Each completes one cycle after accept.
//   Overflow: a=0x7FFF_FFFF_FFFF_FFFE, b=0x0000_0000_0000_0001 -> res=+inf.
//     Same operands with b negated (0xFFFF_FFFF_FFFF_FFFF) -> -inf.
//   Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//     res must stay stable, in_ready=0, and a second in_valid is not accepted until the cycle after out_ready=1.
//   Reset mid-operation: assert reset at iteration 40 -> next cycle IDLE, out_valid=0, in_ready=1.
//     A fresh 3.0/2.0 then yields 0x0001_8000_0000_0000.

Source files
------------

// File: rtl/q15_pkg.sv
// Shared Q15 fixed-point definitions.
// Operand/result width and fractional bits, the special encodings
// (NaN, +inf, -inf, one) and the divider FSM state type.
package q15_pkg;

    localparam int Q15_WIDTH = 64;
    localparam int Q15_FRAC  = 48;

    localparam logic [Q15_WIDTH-1:0] Q15_NAN     = 64'h8000_0000_0000_0000;
    localparam logic [Q15_WIDTH-1:0] Q15_POS_INF = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [Q15_WIDTH-1:0] Q15_NEG_INF = 64'h8000_0000_0000_0001;
    localparam logic [Q15_WIDTH-1:0] Q15_ONE     = 64'h0001_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/q15_decoder.sv
// Q15 operand classifier.
// Ports:
//   x    in   WIDTH  operand
//   sign out  1      two's-complement sign bit
//   nan  out  1      x is the NaN encoding
//   zero out  1      x is zero
//   inf  out  1      x is +inf or -inf
module q15_decoder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    output logic             sign,
    output logic             nan,
    output logic             zero,
    output logic             inf
);

    localparam logic [WIDTH-1:0] NAN_V  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] PINF_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NINF_V = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    assign sign = x[WIDTH-1];
    assign nan  = (x == NAN_V);
    assign zero = (x == '0);
    assign inf  = (x == PINF_V) || (x == NINF_V);

endmodule

// File: rtl/q15_div_core.sv
// Unsigned radix-2 restoring divider core, one quotient bit per cycle.
// Ports:
//   clk, reset  clock and synchronous active-high reset (control only)
//   start  in   1            load n/d and begin WIDTH+FRAC iterations
//   n      in   WIDTH+FRAC   dividend magnitude (already shifted by FRAC)
//   d      in   WIDTH        divisor magnitude
//   done   out  1            one-cycle pulse after the last iteration
//   q      out  WIDTH        low WIDTH bits of the quotient
//   ovf    out  1            a quotient bit at or above WIDTH-1 is set
module q15_div_core #(
    parameter int WIDTH = 64,
    parameter int FRAC  = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH+FRAC-1:0] n,
    input  logic [WIDTH-1:0]      d,
    output logic                  done,
    output logic [WIDTH-1:0]      q,
    output logic                  ovf
);

    localparam int NW = WIDTH + FRAC;
    localparam int CW = $clog2(NW);

    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] cnt_q;

    logic [NW-1:0]    n_q;
    logic [NW-1:0]    quo_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_d;
    logic             qbit_d;
    logic [WIDTH+1:0] trial;

    // Shift the next dividend bit into the remainder and try to subtract.
    always_comb begin
        trial = {rem_q, n_q[NW-1]};
        if (trial >= {2'b00, d_q}) begin
            rem_d  = (WIDTH+1)'(trial - {2'b00, d_q});
            qbit_d = 1'b1;
        end else begin
            rem_d  = trial[WIDTH:0];
            qbit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
            end else if (busy_q) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(NW-1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            n_q   <= n;
            d_q   <= d;
            rem_q <= '0;
            quo_q <= '0;
        end else if (busy_q) begin
            n_q   <= n_q << 1;
            rem_q <= rem_d;
            quo_q <= {quo_q[NW-2:0], qbit_d};
        end
    end

    assign done = done_q;
    assign q    = quo_q[WIDTH-1:0];
    // Any quotient bit from WIDTH-1 upward cannot be represented as a positive result.
    assign ovf  = |quo_q[NW-1:WIDTH-1];

endmodule

// File: rtl/q15_divider.sv
// Sequential signed Q15 divider: res = a / b with NaN/inf/zero handling.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (ready only in IDLE)
//   a, b                 signed dividend / divisor
//   out_valid/out_ready  result handshake, res held while out_ready=0
//   res                  signed quotient or special encoding
module q15_divider
    import q15_pkg::*;
#(
    parameter int WIDTH = Q15_WIDTH,
    parameter int FRAC  = Q15_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sign_q;

    logic sa, sb, a_nan, b_nan, a_zero, b_zero, a_inf, b_inf;
    logic capture, sp_nan, sp_inf, sp_zero, special;
    logic [WIDTH-1:0] special_res;
    logic             core_start, core_done, core_ovf;
    logic [WIDTH-1:0] core_q;

    // 0x8000..0 is NaN and never reaches here, so negation cannot overflow.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // Saturate to signed inf on overflow, otherwise apply the sign; zero stays +0.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] q,
                                                  input logic ovf, input logic neg);
        if (ovf || q >= Q15_POS_INF) return neg ? Q15_NEG_INF : Q15_POS_INF;
        if (q == '0)                 return '0;
        return neg ? -q : q;
    endfunction

    q15_decoder #(.WIDTH(WIDTH)) u_dec_a (
        .x(a), .sign(sa), .nan(a_nan), .zero(a_zero), .inf(a_inf)
    );
    q15_decoder #(.WIDTH(WIDTH)) u_dec_b (
        .x(b), .sign(sb), .nan(b_nan), .zero(b_zero), .inf(b_inf)
    );

    assign capture = (state_q == IDLE) && in_valid;

    // Special cases in priority order; zero carries sign 0, so sa^sb covers b=0.
    always_comb begin
        sp_nan  = a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero);
        sp_inf  = a_inf || (b_zero && !a_zero);
        sp_zero = a_zero || b_inf;
        special = sp_nan || sp_inf || sp_zero;
        if (sp_nan)      special_res = Q15_NAN;
        else if (sp_inf) special_res = (sa ^ sb) ? Q15_NEG_INF : Q15_POS_INF;
        else             special_res = '0;
    end

    assign core_start = capture && !special;

    q15_div_core #(.WIDTH(WIDTH), .FRAC(FRAC)) u_core (
        .clk   (clk),
        .reset (reset),
        .start (core_start),
        .n     ({mag(a), {FRAC{1'b0}}}),
        .d     (mag(b)),
        .done  (core_done),
        .q     (core_q),
        .ovf   (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) sign_q <= sa ^ sb;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = special ? DONE : DIV;
            DIV:     if (core_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_d = res_q;
        if (capture && special)                  res_d = special_res;
        else if (state_q == DIV && core_done)    res_d = saturate(core_q, core_ovf, sign_q);
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign res = res_q;

endmodule

// File: tb/tb_q15_divider.sv
module tb_q15_divider;

    localparam logic [63:0] NAN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PINF = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NINF = 64'h8000_0000_0000_0001;
    localparam int          TMO  = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] res;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    q15_divider dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res)
    );

    always #5 clk = ~clk;

    // Independent reference: wide integer division on magnitudes.
    function automatic logic [63:0] ref_div(input logic [63:0] x, input logic [63:0] y);
        logic sx, sy, xn, yn, xz, yz, xi, yi;
        logic [63:0]  mx, my, q64;
        logic [127:0] q;
        sx = x[63]; sy = y[63];
        xn = (x == NAN); yn = (y == NAN);
        xz = (x == 0);   yz = (y == 0);
        xi = (x == PINF) || (x == NINF);
        yi = (y == PINF) || (y == NINF);
        if (xn || yn || (xi && yi) || (xz && yz)) return NAN;
        if (xi || (yz && !xz)) return (sx ^ sy) ? NINF : PINF;
        if (xz || yi) return 64'h0;
        mx = sx ? -x : x;
        my = sy ? -y : y;
        q = ({64'h0, mx} << 48) / {64'h0, my};
        if (q >= 128'h7FFF_FFFF_FFFF_FFFF) return (sx ^ sy) ? NINF : PINF;
        q64 = q[63:0];
        if (q64 == 0) return 64'h0;
        return (sx ^ sy) ? -q64 : q64;
    endfunction

    // Drive one operand pair through the accept edge and queue its expectation.
    task automatic issue(input logic [63:0] x, input logic [63:0] y);
        sb_q.push_back(ref_div(x, y));
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid (1 = right after accept).
    task automatic wait_out(output int cyc, output bit ok);
        cyc = 1;
        while (!out_valid && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 64'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b res=%h, want 1 0 0", in_ready, out_valid, res);
        end
    endtask

    task automatic test_regular();
        logic [63:0] ta[2] = '{64'h0003_0000_0000_0000, 64'hFFFF_0000_0000_0000};
        logic [63:0] tb[2] = '{64'h0002_0000_0000_0000, 64'h0003_0000_0000_0000};
        logic [63:0] te[2] = '{64'h0001_8000_0000_0000, 64'hFFFF_AAAA_AAAA_AAAB};
        logic [63:0] exp;
        int cyc; bit ok;
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL regular_busy[%0d]: in_ready=%b, want 0", i, in_ready);
            end
            wait_out(cyc, ok);
            exp = sb_q.pop_front();
            checks++;
            if (!ok || cyc != 114) begin
                errors++;
                $display("FAIL regular_latency[%0d]: got %0d cycles, want 114", i, cyc);
            end
            checks++;
            if (res !== exp || res !== te[i]) begin
                errors++;
                $display("FAIL regular_res[%0d]: got %h, want %h", i, res, te[i]);
            end
            release_out();
        end
    endtask

    task automatic test_specials();
        logic [63:0] ta[6] = '{64'h0001_0000_0000_0000, 64'hFFFF_0000_0000_0000, 64'h0,
                               NAN, 64'h0001_0000_0000_0000, PINF};
        logic [63:0] tb[6] = '{64'h0, 64'h0, 64'h0, 64'h0001_0000_0000_0000, PINF,
                               64'hFFFF_0000_0000_0000};
        logic [63:0] te[6] = '{PINF, NINF, NAN, NAN, 64'h0, NINF};
        logic [63:0] exp;
        int cyc; bit ok;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i]);
            wait_out(cyc, ok);
            exp = sb_q.pop_front();
            checks++;
            if (!ok || cyc != 1 || res !== exp || res !== te[i]) begin
                errors++;
                $display("FAIL special[%0d]: res=%h after %0d cycles, want %h after 1", i, res, cyc, te[i]);
            end
            release_out();
        end
    endtask

    task automatic test_overflow();
        logic [63:0] tb[2] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] te[2] = '{PINF, NINF};
        logic [63:0] exp;
        int cyc; bit ok;
        for (int i = 0; i < 2; i++) begin
            issue(64'h7FFF_FFFF_FFFF_FFFE, tb[i]);
            wait_out(cyc, ok);
            exp = sb_q.pop_front();
            checks++;
            if (!ok || res !== exp || res !== te[i]) begin
                errors++;
                $display("FAIL overflow[%0d]: got %h, want %h", i, res, te[i]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        int cyc; bit ok;
        issue(64'h0003_0000_0000_0000, 64'h0002_0000_0000_0000);
        wait_out(cyc, ok);
        exp = sb_q.pop_front();
        checks++;
        if (!ok || res !== exp) begin
            errors++;
            $display("FAIL bp_first: got %h, want %h", res, exp);
        end
        // Offer a second operand pair while the result is held.
        a = 64'h0005_0000_0000_0000; b = 64'h0001_0000_0000_0000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: res=%h ov=%b ir=%b, want %h 1 0", i, res, out_valid, in_ready, exp);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        sb_q.push_back(ref_div(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b, want 0", in_ready);
        end
        wait_out(cyc, ok);
        exp = sb_q.pop_front();
        checks++;
        if (!ok || res !== exp || res !== 64'h0005_0000_0000_0000) begin
            errors++;
            $display("FAIL bp_second: got %h, want %h", res, exp);
        end
        release_out();
    endtask

    task automatic test_reset_midop();
        logic [63:0] exp;
        int cyc; bit ok;
        issue(64'h0007_0000_0000_0000, 64'h0002_0000_0000_0000);
        void'(sb_q.pop_front());
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 64'h0) begin
            errors++;
            $display("FAIL midop_reset: ir=%b ov=%b res=%h, want 1 0 0", in_ready, out_valid, res);
        end
        issue(64'h0003_0000_0000_0000, 64'h0002_0000_0000_0000);
        wait_out(cyc, ok);
        exp = sb_q.pop_front();
        checks++;
        if (!ok || cyc != 114 || res !== exp || res !== 64'h0001_8000_0000_0000) begin
            errors++;
            $display("FAIL midop_fresh: res=%h after %0d cycles, want 0001800000000000 after 114", res, cyc);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic signed [63:0] x, y;
        logic [63:0] exp;
        int cyc; bit ok;
        for (int i = 0; i < 8; i++) begin
            x = $signed({$urandom, $urandom}) >>> $urandom_range(0, 40);
            y = $signed({$urandom, $urandom}) >>> $urandom_range(8, 60);
            if (i == 7) y = 64'sh0;
            issue(x, y);
            wait_out(cyc, ok);
            exp = sb_q.pop_front();
            checks++;
            if (!ok || res !== exp) begin
                errors++;
                $display("FAIL b2b[%0d]: a=%h b=%h got %h, want %h", i, x, y, res, exp);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_regular();
        test_specials();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
